// File: rtl/osc_phase_accum.sv
// rtl/osc_phase_accum.sv - time-multiplexed per-oscillator phase accumulator
module osc_phase_accum #(
    parameter int VOICES      = 8,
    parameter int V_OSC       = 4,
    parameter int V_WIDTH     = 3,
    parameter int O_WIDTH     = 2,
    parameter int OE_WIDTH    = 1,
    parameter int E_WIDTH     = O_WIDTH + OE_WIDTH,
    parameter int PHASE_WIDTH = 32,
    parameter int PITCH_LAT   = 3
) (
    input  logic                       sCLK_XVXOSC,
    input  logic                       reset_data,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic [23:0]                osc_pitch_val,
    input  logic                       note_on,
    input  logic [V_WIDTH-1:0]         cur_key_adr,
    input  logic [V_OSC-1:0]           sync_en,
    output logic [PHASE_WIDTH-1:0]     phase_out,
    output logic [V_WIDTH-1:0]         phase_vx,
    output logic [O_WIDTH-1:0]         phase_ox,
    output logic                       wrap_out,
    output logic                       phase_valid,
    output logic                       init_done
);

    localparam int SW = V_WIDTH + E_WIDTH;
    localparam int IW = V_WIDTH + O_WIDTH;
    localparam int N  = VOICES * V_OSC;
    localparam int FW = $clog2(PITCH_LAT + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [IW-1:0]        sweep;
    logic [FW-1:0]        fill;
    logic [SW-1:0]        slot_dly [PITCH_LAT];
    logic [PHASE_WIDTH-1:0] mem [N];
    logic [N-1:0]         restart_pend, sync_pend;
    logic [N-1:0]         restart_nx, sync_nx;

    logic [SW-1:0]        dslot;
    logic [V_WIDTH-1:0]   dv;
    logic [O_WIDTH-1:0]   dox;
    logic [OE_WIDTH-1:0]  de;
    logic [IW-1:0]        idx;
    logic [PHASE_WIDTH-1:0] cur;
    logic [PHASE_WIDTH:0] sum;
    logic [V_OSC-1:0]     sync_hi;
    logic                 upd, visit, restart, carry;

    // Delayed slot lines up with osc_pitch_val, which trails xxxx by PITCH_LAT
    assign dslot   = slot_dly[PITCH_LAT-1];
    assign dv      = dslot[SW-1:E_WIDTH];
    assign dox     = dslot[E_WIDTH-1:OE_WIDTH];
    assign de      = dslot[OE_WIDTH-1:0];
    assign idx     = {dv, dox};
    assign cur     = mem[idx];
    assign sum     = {1'b0, cur} + (PHASE_WIDTH+1)'(osc_pitch_val);
    assign upd     = (state == ST_RUN) && (fill == FW'(PITCH_LAT));
    assign visit   = upd && (de == '0);
    assign restart = visit && (restart_pend[idx] || sync_pend[idx]);
    assign carry   = visit && !restart && sum[PHASE_WIDTH];
    // sync_hi[o] is the sync enable of the oscillator after o; the last one has none
    assign sync_hi = sync_en >> 1;

    // Clears are applied before sets so a same-cycle set survives
    always_comb begin
        restart_nx = restart_pend;
        sync_nx    = sync_pend;
        if (restart) begin
            restart_nx[idx] = 1'b0;
            sync_nx[idx]    = 1'b0;
        end
        if (carry && sync_hi[dox]) begin
            sync_nx[idx + IW'(1)] = 1'b1;
        end
        if (state == ST_RUN && note_on) begin
            for (int o = 0; o < V_OSC; o++) begin
                restart_nx[{cur_key_adr, O_WIDTH'(o)}] = 1'b1;
            end
        end
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        if (!reset_data) begin
            if (state == ST_INIT) begin
                mem[sweep] <= '0;
            end else if (visit) begin
                mem[idx] <= restart ? '0 : sum[PHASE_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset_data) begin
            state        <= ST_INIT;
            sweep        <= '0;
            fill         <= '0;
            restart_pend <= '0;
            sync_pend    <= '0;
            phase_out    <= '0;
            phase_vx     <= '0;
            phase_ox     <= '0;
            wrap_out     <= 1'b0;
            phase_valid  <= 1'b0;
            init_done    <= 1'b0;
            for (int i = 0; i < PITCH_LAT; i++) begin
                slot_dly[i] <= '0;
            end
        end else begin
            slot_dly[0] <= xxxx;
            for (int i = 1; i < PITCH_LAT; i++) begin
                slot_dly[i] <= slot_dly[i-1];
            end
            restart_pend <= restart_nx;
            sync_pend    <= sync_nx;
            phase_valid  <= upd;
            wrap_out     <= carry;
            if (upd) begin
                phase_vx <= dv;
                phase_ox <= dox;
                if (!visit) begin
                    phase_out <= cur;
                end else if (restart) begin
                    phase_out <= '0;
                end else begin
                    phase_out <= sum[PHASE_WIDTH-1:0];
                end
            end else begin
                phase_vx  <= '0;
                phase_ox  <= '0;
                phase_out <= '0;
            end
            case (state)
                ST_INIT: begin
                    sweep <= sweep + IW'(1);
                    if (sweep == IW'(N - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fill != FW'(PITCH_LAT)) begin
                        fill <= fill + FW'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/osc_phase_accum.md
Name: osc_phase_accum

Overview:
- Time-multiplexed phase accumulator directly downstream of the pitch stage.
- Consumes the per-slot 24-bit phase increment (osc_pitch_val) and holds one phase word per voice/oscillator.
- Adds the increment once per frame and presents the running phase, slot tags and a wrap flag to the waveform/lookup stage.
- Handles key-on phase restart and oscillator hard sync.

Parameters:
- VOICES, 8, number of voices.
- V_OSC, 4, oscillators per voice.
- V_WIDTH, 3, voice index width.
- O_WIDTH, 2, oscillator index width.
- OE_WIDTH, 1, sub-slot index width.
- E_WIDTH, O_WIDTH+OE_WIDTH, combined osc/sub-slot width.
- PHASE_WIDTH, 32, phase accumulator width; must be ≥ 24.
- PITCH_LAT, 3, cycles from a slot index appearing on xxxx to its increment appearing on osc_pitch_val.

Ports:
- sCLK_XVXOSC, in, 1: slot clock, one slot per cycle.
- reset_data, in, 1: synchronous, active-high reset.
- xxxx, in, V_WIDTH+E_WIDTH: current slot. Voice is bits [V_WIDTH+E_WIDTH-1:E_WIDTH]; osc is bits [E_WIDTH-1:OE_WIDTH]; sub-slot is bits [OE_WIDTH-1:0].
- osc_pitch_val, in, 24: unsigned phase increment for the slot issued PITCH_LAT cycles earlier.
- note_on, in, 1: single-cycle key-on strobe in the sCLK_XVXOSC domain.
- cur_key_adr, in, V_WIDTH: voice restarted by note_on.
- sync_en, in, V_OSC: sync_en[o]=1 hard-syncs osc o to osc o-1 of the same voice; bit 0 is ignored.
- phase_out, out, PHASE_WIDTH: phase of the tagged slot.
- phase_vx, out, V_WIDTH: voice tag of phase_out.
- phase_ox, out, O_WIDTH: osc tag of phase_out.
- wrap_out, out, 1: the accumulation that produced phase_out carried out of PHASE_WIDTH.
- phase_valid, out, 1: phase_out and its tags are valid.
- init_done, out, 1: phase memory clear sweep is complete.

Behaviour:
- Storage:
  - Phase memory: VOICES*V_OSC words of PHASE_WIDTH bits, indexed {vx,ox}.
  - restart_pend: VOICES*V_OSC bits.
  - sync_pend: VOICES*V_OSC bits.
- State machine INIT/RUN:
  - reset_data=1 forces INIT on the next edge and zeroes the sweep counter, restart_pend, sync_pend, all outputs and the slot delay line. This applies at any time, including mid-operation.
  - In INIT, one memory word per cycle is written to 0, starting with the cycle after reset deasserts.
  - After VOICES*V_OSC writes (32 cycles at default), the block enters RUN and init_done goes to 1.
  - In INIT, phase_valid=0, phase_out=0, wrap_out=0, and note_on is ignored.
- Slot alignment: xxxx passes through a PITCH_LAT-deep register delay so that the delayed slot {dv,do,de} and osc_pitch_val refer to the same slot.
- Update, RUN only, one pipeline stage. Result registered; phase_out appears 1 cycle after osc_pitch_val, i.e. PITCH_LAT+1 cycles after xxxx.
  - de≠0: read only. phase_out = mem[dv,do], wrap_out=0, no write.
  - de=0 and restart_pend[dv,do]=1: write mem=0, phase_out=0, wrap_out=0, clear the bit.
  - de=0 and sync_pend[dv,do]=1 (restart not pending): same as the restart case, clearing the sync bit.
  - Otherwise: sum = mem + zero-extended osc_pitch_val, modulo 2^PHASE_WIDTH. Write sum back, phase_out = sum, wrap_out = carry.
  - If osc do produces wrap_out=1, do+1 < V_OSC and sync_en[do+1]=1, set sync_pend[dv,do+1].
- Tags and validity:
  - phase_valid=1 every RUN cycle once the delay line has filled (PITCH_LAT cycles after entering RUN).
  - phase_vx and phase_ox equal dv and do, registered with phase_out.
- note_on in RUN sets restart_pend for all V_OSC oscillators of voice cur_key_adr.
- Conflicts:
  - Set and clear of the same pending bit in the same cycle: set wins, so a restart still occurs on the next visit.
  - Restart and sync pending together: both bits are cleared and one restart occurs.
- Arithmetic: unsigned throughout; no saturation.

Test Plan:
- Reset sweep: pulse reset_data for 2 cycles → init_done=0 for exactly 32 cycles after deassert, then 1. First valid phase_out of every slot equals 0+increment.
- Accumulate: constant osc_pitch_val=0x100000 for v0/o0 → phase_out on successive de=0 visits is 0x100000, 0x200000, 0x300000. The de=1 visit repeats the preceding value.
- Wrap: PHASE_WIDTH=24, increment 0x400000 → values 0x400000, 0x800000, 0xC00000, 0x000000 with wrap_out=1 on the 4th visit only.
- Restart: after 5 frames, note_on with cur_key_adr=2 → next de=0 visit of each osc of voice 2 yields phase_out=0. Voice 3 is unaffected. The following frame yields the increment.
- Hard sync: sync_en=4'b0010, osc0 wraps in frame N → osc1 of the same voice outputs 0 in frame N+1. With sync_en=0, osc1 keeps accumulating.
- Reset mid-run: assert reset_data during RUN → phase_valid=0 on the next cycle, a full 32-cycle sweep follows, and pending restarts are discarded.
